// File: rtl/atomrvcore_iccm_loader.sv
// ---------------------------------------------------------------------------
// atomrvcore_iccm_loader
//
// Boot-time ICCM writer. It consumes a byte stream over a valid/ready
// handshake. The stream is a 4-byte little-endian word count N followed by
// N little-endian 32-bit words. Each assembled word is written into the ICCM
// write port as a one-cycle IWR_EN_o pulse. The fetch unit's PC reset is held
// asserted until the last word has been written.
//
// Ports
//   clk_i         core clock, rising edge
//   rst_i         synchronous active-high reset
//   byte_i        stream byte
//   byte_valid_i  byte_i is valid
//   byte_ready_o  loader accepts byte_i this cycle (HDR / LOAD only)
//   DATA_o        word to ICCM DATA_i (holds last written word)
//   address_o     byte address to ICCM address_i (holds last written address)
//   IWR_EN_o      ICCM write enable, one pulse per word
//   PCrst_o       fetch-unit PC reset, high until the load completes
//   done_o        load finished successfully (sticky until reset)
//   err_o         header count exceeded DEPTH (sticky until reset)
// ---------------------------------------------------------------------------
module atomrvcore_iccm_loader #(
    parameter int                  DATAWIDTH = 32,
    parameter logic [DATAWIDTH-1:0] BASE_ADDR = '0,
    parameter int                  DEPTH     = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           byte_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output logic [DATAWIDTH-1:0] DATA_o,
    output logic [DATAWIDTH-1:0] address_o,
    output logic                 IWR_EN_o,
    output logic                 PCrst_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             lane_q,  lane_d;
    logic [23:0]            asm_q,   asm_d;    // first three bytes of the current header/word
    logic [31:0]            n_q,     n_d;      // declared word count
    logic [31:0]            wcnt_q,  wcnt_d;   // words written so far
    logic [DATAWIDTH-1:0]   data_q,  data_d;
    logic [DATAWIDTH-1:0]   addr_q,  addr_d;

    logic        accept;
    logic [31:0] full_word;
    logic [31:0] wcnt_inc;

    assign byte_ready_o = (state_q == S_HDR) || (state_q == S_LOAD);
    assign accept       = byte_valid_i && byte_ready_o;

    // Bytes are shifted in from the top, so after three bytes asm_q holds
    // {b2,b1,b0} and the fourth byte completes the little-endian word.
    assign full_word    = {byte_i, asm_q};
    assign wcnt_inc     = wcnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        addr_d  = addr_q;

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    asm_d  = {byte_i, asm_q[23:8]};
                    if (lane_q == 2'd3) begin
                        n_d = full_word;
                        if (full_word == 32'd0) begin
                            state_d = S_DONE;
                        end else if (full_word > DEPTH_W) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_LOAD;
                        end
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    asm_d  = {byte_i, asm_q[23:8]};
                    if (lane_q == 2'd3) begin
                        // Present the word and its address for the whole WRITE
                        // cycle; both registers then hold until the next word.
                        data_d  = DATAWIDTH'(full_word);
                        addr_d  = BASE_ADDR + DATAWIDTH'({wcnt_q[29:0], 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                wcnt_d  = wcnt_inc;
                state_d = (wcnt_inc == n_q) ? S_DONE : S_LOAD;
            end

            S_DONE: state_d = S_DONE;

            S_ERR:  state_d = S_ERR;

            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_HDR;
            lane_q  <= '0;
            asm_q   <= '0;
            n_q     <= '0;
            wcnt_q  <= '0;
            data_q  <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // A reset arriving during WRITE must suppress the pulse in that cycle.
    assign IWR_EN_o  = (state_q == S_WRITE) && !rst_i;
    assign DATA_o    = data_q;
    assign address_o = addr_q;
    assign PCrst_o   = (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign err_o     = (state_q == S_ERR);

endmodule

// File: tb/tb_atomrvcore_iccm_loader.sv
module tb_atomrvcore_iccm_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic [DW-1:0] DATA_o;
    logic [DW-1:0] address_o;
    logic          IWR_EN_o;
    logic          PCrst_o;
    logic          done_o;
    logic          err_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] wd[$];
    logic [31:0] wa[$];

    atomrvcore_iccm_loader #(
        .DATAWIDTH(DW),
        .BASE_ADDR(32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .DATA_o      (DATA_o),
        .address_o   (address_o),
        .IWR_EN_o    (IWR_EN_o),
        .PCrst_o     (PCrst_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // ICCM-side write log, sampled mid-cycle
    always @(negedge clk_i) begin
        if (IWR_EN_o === 1'b1) begin
            wd.push_back(DATA_o);
            wa.push_back(address_o);
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wd.delete();
        wa.delete();
    endtask

    // Offer one byte; returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int cnt;
        byte_i = b;
        byte_valid_i = 1'b1;
        cnt = 0;
        @(negedge clk_i);
        while (byte_ready_o !== 1'b1 && cnt < 100) begin
            @(negedge clk_i);
            cnt++;
        end
        if (cnt >= 100) begin
            n_chk++; n_fail++;
            $display("FAIL send_byte_timeout: ready=%b after %0d cycles, required 1", byte_ready_o, cnt);
        end
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        idle(2);
        rst_i = 1'b0;
        wd.delete(); wa.delete();
        n_chk++; if (byte_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", byte_ready_o); end
        n_chk++; if (IWR_EN_o !== 1'b0) begin n_fail++; $display("FAIL rst_iwr: got %b want 0", IWR_EN_o); end
        n_chk++; if (DATA_o !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", DATA_o); end
        n_chk++; if (address_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", address_o); end
        n_chk++; if (PCrst_o !== 1'b1) begin n_fail++; $display("FAIL rst_pcrst: got %b want 1", PCrst_o); end
        n_chk++; if (done_o !== 1'b0 || err_o !== 1'b0) begin n_fail++; $display("FAIL rst_flags: done=%b err=%b want 0 0", done_o, err_o); end
    endtask

    task automatic test_two_words();
        do_reset();
        send_word(32'd2);
        send_word(32'h0000_0013);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10);
        n_chk++; if (PCrst_o !== 1'b1) begin n_fail++; $display("FAIL two_pcrst_early: got %b want 1", PCrst_o); end
        send_byte(8'h00);
        @(negedge clk_i);
        n_chk++; if (IWR_EN_o !== 1'b1 || byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL two_write_cycle: iwr=%b ready=%b want 1 0", IWR_EN_o, byte_ready_o); end
        n_chk++; if (PCrst_o !== 1'b1) begin n_fail++; $display("FAIL two_pcrst_in_write: got %b want 1", PCrst_o); end
        @(posedge clk_i); #1;
        n_chk++; if (PCrst_o !== 1'b0 || done_o !== 1'b1) begin n_fail++; $display("FAIL two_done: pcrst=%b done=%b want 0 1", PCrst_o, done_o); end
        idle(4);
        n_chk++; if (wd.size() != 2) begin n_fail++; $display("FAIL two_count: got %0d want 2", wd.size()); end
        else begin
            n_chk++; if (wd[0] !== 32'h0000_0013 || wa[0] !== 32'h0) begin n_fail++; $display("FAIL two_w0: got %h@%h want 00000013@00000000", wd[0], wa[0]); end
            n_chk++; if (wd[1] !== 32'h0010_0093 || wa[1] !== 32'h4) begin n_fail++; $display("FAIL two_w1: got %h@%h want 00100093@00000004", wd[1], wa[1]); end
        end
        n_chk++; if (DATA_o !== 32'h0010_0093 || address_o !== 32'h4) begin n_fail++; $display("FAIL two_hold: got %h@%h want 00100093@00000004", DATA_o, address_o); end
    endtask

    task automatic test_zero();
        do_reset();
        send_word(32'd0);
        n_chk++; if (done_o !== 1'b1 || PCrst_o !== 1'b0) begin n_fail++; $display("FAIL zero_done: done=%b pcrst=%b want 1 0", done_o, PCrst_o); end
        n_chk++; if (byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %b want 0", byte_ready_o); end
        byte_i = 8'h55; byte_valid_i = 1'b1;
        idle(6);
        byte_valid_i = 1'b0;
        n_chk++; if (wd.size() != 0 || done_o !== 1'b1) begin n_fail++; $display("FAIL zero_nowrite: writes=%0d done=%b want 0 1", wd.size(), done_o); end
    endtask

    task automatic test_err();
        do_reset();
        send_word(32'd1025);
        n_chk++; if (err_o !== 1'b1 || PCrst_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL err_flags: err=%b pcrst=%b done=%b want 1 1 0", err_o, PCrst_o, done_o); end
        n_chk++; if (byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL err_ready: got %b want 0", byte_ready_o); end
        byte_i = 8'hAA; byte_valid_i = 1'b1;
        idle(10);
        byte_valid_i = 1'b0;
        n_chk++; if (wd.size() != 0 || err_o !== 1'b1 || PCrst_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky: writes=%0d err=%b pcrst=%b want 0 1 1", wd.size(), err_o, PCrst_o); end
    endtask

    task automatic test_gaps();
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        do_reset();
        send_word(32'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i < 3) idle(2);
        end
        @(negedge clk_i);
        n_chk++; if (IWR_EN_o !== 1'b1 || byte_ready_o !== 1'b0) begin n_fail++; $display("FAIL gap_write_cycle: iwr=%b ready=%b want 1 0", IWR_EN_o, byte_ready_o); end
        idle(3);
        n_chk++; if (wd.size() != 1) begin n_fail++; $display("FAIL gap_count: got %0d want 1", wd.size()); end
        else begin
            n_chk++; if (wd[0] !== 32'hDEAD_BEEF || wa[0] !== 32'h0) begin n_fail++; $display("FAIL gap_word: got %h@%h want deadbeef@00000000", wd[0], wa[0]); end
        end
        n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL gap_done: got %b want 1", done_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(32'd3);
        send_byte(8'h11); send_byte(8'h22);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_chk++; if (byte_ready_o !== 1'b1 || PCrst_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0 || address_o !== 32'h0 || DATA_o !== 32'h0)
            begin n_fail++; $display("FAIL mid_rst_vals: ready=%b pcrst=%b done=%b err=%b addr=%h data=%h", byte_ready_o, PCrst_o, done_o, err_o, address_o, DATA_o); end
        send_word(32'd1);
        send_word(32'hCAFE_BABE);
        idle(3);
        n_chk++; if (wd.size() != 1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", wd.size()); end
        else begin
            n_chk++; if (wd[0] !== 32'hCAFE_BABE || wa[0] !== 32'h0) begin n_fail++; $display("FAIL mid_word: got %h@%h want cafebabe@00000000", wd[0], wa[0]); end
        end
        n_chk++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL mid_done: got %b want 1", done_o); end
    endtask

    task automatic test_reset_in_write();
        do_reset();
        send_word(32'd1);
        send_word(32'h1234_5678);
        rst_i = 1'b1;
        @(negedge clk_i);
        n_chk++; if (IWR_EN_o !== 1'b0) begin n_fail++; $display("FAIL wrst_iwr: got %b want 0", IWR_EN_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        n_chk++; if (DATA_o !== 32'h0 || PCrst_o !== 1'b1 || done_o !== 1'b0 || byte_ready_o !== 1'b1)
            begin n_fail++; $display("FAIL wrst_vals: data=%h pcrst=%b done=%b ready=%b", DATA_o, PCrst_o, done_o, byte_ready_o); end
        idle(3);
        n_chk++; if (wd.size() != 0) begin n_fail++; $display("FAIL wrst_nowrite: got %0d want 0", wd.size()); end
    endtask

    task automatic test_depth();
        int bad;
        logic [31:0] w;
        do_reset();
        send_word(32'd1024);
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i), 8'h5A, 16'(i)};
            send_word(w);
        end
        idle(3);
        n_chk++; if (wd.size() != DEPTH) begin n_fail++; $display("FAIL depth_count: got %0d want %0d", wd.size(), DEPTH); end
        else begin
            bad = 0;
            for (int i = 0; i < DEPTH; i++) begin
                w = {8'(i), 8'h5A, 16'(i)};
                if (wd[i] !== w || wa[i] !== 32'(4 * i)) bad++;
            end
            n_chk++; if (bad != 0) begin n_fail++; $display("FAIL depth_words: %0d wrong, want 0", bad); end
            n_chk++; if (wa[DEPTH-1] !== 32'h0000_0FFC) begin n_fail++; $display("FAIL depth_last_addr: got %h want 00000ffc", wa[DEPTH-1]); end
        end
        n_chk++; if (done_o !== 1'b1 || err_o !== 1'b0 || PCrst_o !== 1'b0) begin n_fail++; $display("FAIL depth_flags: done=%b err=%b pcrst=%b want 1 0 0", done_o, err_o, PCrst_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        byte_i = 8'h00;
        test_reset();
        test_two_words();
        test_zero();
        test_err();
        test_gaps();
        test_reset_mid();
        test_reset_in_write();
        test_depth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
